// File: rtl/snowv_pkg.sv
// Shared definitions for the SNOW-V keystream consumer: block width,
// block type and the data-width legality check.
package snowv_pkg;

  localparam int KS_W = 128;

  typedef logic [KS_W-1:0] ks_block_t;

  // A data width is usable only if a whole number of words fills one block.
  function automatic bit dw_legal(input int dw);
    return (dw == 8) || (dw == 16) || (dw == 32) || (dw == 64) || (dw == 128);
  endfunction

endpackage

// File: rtl/snowv_keystream_xor_if.sv
// Keystream, input-data and output-data handshakes plus the word counter.
// "slave" is the XOR block's view, "master" is the surrounding system's view.
interface snowv_keystream_xor_if #(
  parameter int DW = 32
);
  import snowv_pkg::*;

  logic            ks_valid;
  logic            ks_ready;
  ks_block_t       ks_data;
  logic            din_valid;
  logic            din_ready;
  logic [DW-1:0]   din_data;
  logic            din_last;
  logic            dout_valid;
  logic            dout_ready;
  logic [DW-1:0]   dout_data;
  logic            dout_last;
  logic [31:0]     words_done;

  modport slave (
    input  ks_valid, ks_data, din_valid, din_data, din_last, dout_ready,
    output ks_ready, din_ready, dout_valid, dout_data, dout_last, words_done
  );

  modport master (
    output ks_valid, ks_data, din_valid, din_data, din_last, dout_ready,
    input  ks_ready, din_ready, dout_valid, dout_data, dout_last, words_done
  );

endinterface

// File: rtl/snowv_ks_fifo.sv
// Two-entry, 128-bit valid/ready FIFO holding keystream blocks.
// A full FIFO still accepts a block in a cycle where the head is popped.
module snowv_ks_fifo
  import snowv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  ks_block_t  i_wr_data,
  output logic       o_rd_valid,
  input  logic       i_rd_ready,
  output ks_block_t  o_rd_data,
  output logic [1:0] o_count
);

  ks_block_t  r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_rd_valid = (r_count != 2'd0);
  assign w_pop      = i_rd_ready && o_rd_valid;
  assign o_wr_ready = !rst && ((r_count < 2'd2) || w_pop);
  assign w_push     = i_wr_valid && o_wr_ready;
  assign o_rd_data  = r_mem[r_rptr];
  assign o_count    = r_count;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Block storage; contents are meaningless until counted as valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

endmodule

// File: rtl/snowv_keystream_xor.sv
// SNOW-V keystream consumer: XORs DW-bit slices of buffered keystream
// blocks onto a data stream. Every message starts on a fresh block.
module snowv_keystream_xor
  import snowv_pkg::*;
#(
  parameter int DW       = 32,
  parameter int KS_DEPTH = 2
)(
  input  logic                  clk,
  input  logic                  rst,
  snowv_keystream_xor_if.slave  bus
);

  localparam int N     = KS_W / DW;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (!dw_legal(DW) || (KS_DEPTH != 2)) begin : g_bad_param
    $error("snowv_keystream_xor: DW must divide 128 and KS_DEPTH must be 2");
  end

  ks_block_t        w_head;
  logic [1:0]       w_count;
  logic             w_head_valid;
  logic             w_din_ready;
  logic             w_xfer;
  logic             w_pop;
  logic [DW-1:0]    w_chunk;

  logic [IDX_W-1:0] r_idx;
  logic             r_vld_p1;
  logic [DW-1:0]    r_dout_p1;
  logic             r_last_p1;
  logic [31:0]      r_words;

  snowv_ks_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (bus.ks_valid),
    .o_wr_ready (bus.ks_ready),
    .i_wr_data  (bus.ks_data),
    .o_rd_valid (w_head_valid),
    .i_rd_ready (w_pop),
    .o_rd_data  (w_head),
    .o_count    (w_count)
  );

  assign w_din_ready = (w_count != 2'd0) && (!r_vld_p1 || bus.dout_ready);
  assign w_xfer      = bus.din_valid && w_din_ready;
  assign w_pop       = w_xfer && ((r_idx == IDX_W'(N - 1)) || bus.din_last);
  assign w_chunk     = w_head[DW*r_idx +: DW];

  assign bus.din_ready  = w_din_ready;
  assign bus.dout_valid = r_vld_p1;
  assign bus.dout_data  = r_dout_p1;
  assign bus.dout_last  = r_last_p1;
  assign bus.words_done = r_words;

  // Stage p0 -> p1: chunk index, XOR output register and word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_vld_p1  <= 1'b0;
      r_dout_p1 <= '0;
      r_last_p1 <= 1'b0;
      r_words   <= 32'd0;
    end else if (w_xfer) begin
      r_idx     <= w_pop ? '0 : r_idx + 1'b1;
      r_vld_p1  <= 1'b1;
      r_dout_p1 <= bus.din_data ^ w_chunk;
      r_last_p1 <= bus.din_last;
      r_words   <= r_words + 32'd1;
    end else if (r_vld_p1 && bus.dout_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snowv_keystream_xor.sv
// Directed bench for snowv_keystream_xor with DW = 32.
module tb_snowv_keystream_xor;

  localparam logic [127:0] K0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] K1 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
  localparam logic [127:0] K2 = 128'h2F2E2D2C_2B2A2928_27262524_23222120;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  snowv_keystream_xor_if #(.DW(32)) bus ();

  snowv_keystream_xor #(.DW(32), .KS_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         pre_push;
    logic [127:0] blk;
    logic [31:0]  din;
    logic         last;
    logic [31:0]  exp;
    logic         exp_last;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.ks_valid = 1'b0; bus.ks_data = '0;
    bus.din_valid = 1'b0; bus.din_data = '0; bus.din_last = 1'b0;
    bus.dout_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic push_block(input logic [127:0] k);
    int n;
    n = 0;
    bus.ks_valid = 1'b1; bus.ks_data = k;
    #1;
    while (!bus.ks_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n == 20) timeout_fail("push_wait");
    else begin
      @(posedge clk); #1;
    end
    bus.ks_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    bus.din_valid = 1'b1; bus.din_data = d; bus.din_last = last;
    #1;
    while (!bus.din_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n == 20) timeout_fail("din_wait");
    else begin
      @(posedge clk); #1;
    end
    bus.din_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    tbl[0] = '{1'b0, '0, 32'hFFFFFFFF, 1'b0, 32'hFCFDFEFF, 1'b0};
    tbl[1] = '{1'b0, '0, 32'hFFFFFFFF, 1'b0, 32'hF8F9FAFB, 1'b0};
    tbl[2] = '{1'b0, '0, 32'hFFFFFFFF, 1'b0, 32'hF4F5F6F7, 1'b0};
    tbl[3] = '{1'b0, '0, 32'hFFFFFFFF, 1'b1, 32'hF0F1F2F3, 1'b1};
    tbl[4] = '{1'b1, K2, 32'h00000000, 1'b0, 32'h13121110, 1'b0};
    tbl[5] = '{1'b0, '0, 32'h12345678, 1'b1, 32'h0522436C, 1'b1};
    tbl[6] = '{1'b0, '0, 32'hA5A5A5A5, 1'b1, 32'h86878485, 1'b1};

    // Reset values, including ks_ready held low while rst is high.
    rst = 1'b1;
    bus.ks_valid = 1'b1; bus.ks_data = K0;
    bus.din_valid = 1'b0; bus.din_data = '0; bus.din_last = 1'b0;
    bus.dout_ready = 1'b1;
    #2;
    chk("rst_ks_ready", bus.ks_ready, 1'b0);
    chk("rst_dout_valid", bus.dout_valid, 1'b0);
    chk("rst_dout_data", bus.dout_data, 32'h0);
    chk("rst_dout_last", bus.dout_last, 1'b0);
    chk("rst_words_done", bus.words_done, 32'd0);
    chk("rst_din_ready", bus.din_ready, 1'b0);

    // Tests 1 and 2: table of words over K0, K1, K2.
    apply_reset();
    push_block(K0);
    push_block(K1);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].pre_push) push_block(tbl[i].blk);
      send_word(tbl[i].din, tbl[i].last);
      chk($sformatf("tbl%0d_valid", i), bus.dout_valid, 1'b1);
      chk($sformatf("tbl%0d_data", i), bus.dout_data, tbl[i].exp);
      chk($sformatf("tbl%0d_last", i), bus.dout_last, tbl[i].exp_last);
      if (i == 3) chk("t1_words_done", bus.words_done, 32'd4);
    end
    chk("t2_words_done", bus.words_done, 32'd7);
    @(posedge clk); #1;
    chk("t2_dout_idle", bus.dout_valid, 1'b0);
    chk("t2_empty_din_ready", bus.din_ready, 1'b0);

    // Test 3: full buffer back-pressure and push alongside a pop.
    apply_reset();
    bus.ks_valid = 1'b1; bus.ks_data = K0;
    @(posedge clk); #1;
    bus.ks_data = K1;
    @(posedge clk); #1;
    bus.ks_data = K2;
    #1;
    chk("t3_full_ks_ready", bus.ks_ready, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t3_full_ks_ready2", bus.ks_ready, 1'b0);
    bus.din_valid = 1'b1; bus.din_data = 32'h0; bus.din_last = 1'b1;
    #1;
    chk("t3_pop_ks_ready", bus.ks_ready, 1'b1);
    chk("t3_pop_din_ready", bus.din_ready, 1'b1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0; bus.ks_valid = 1'b0;
    #1;
    chk("t3_dout", bus.dout_data, 32'h03020100);
    chk("t3_still_full", bus.ks_ready, 1'b0);
    send_word(32'h0, 1'b1);
    chk("t3_k1", bus.dout_data, 32'h13121110);
    send_word(32'h0, 1'b1);
    chk("t3_k2", bus.dout_data, 32'h23222120);
    chk("t3_drained", bus.din_ready, 1'b0);

    // Test 4: output stall holds data and blocks input.
    apply_reset();
    push_block(K0);
    bus.dout_ready = 1'b0;
    bus.din_valid = 1'b1; bus.din_data = 32'h11111111; bus.din_last = 1'b0;
    #1;
    chk("t4_first_ready", bus.din_ready, 1'b1);
    @(posedge clk); #1;
    bus.din_data = 32'h22222222;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t4_stall%0d_ready", c), bus.din_ready, 1'b0);
      chk($sformatf("t4_stall%0d_data", c), bus.dout_data, 32'h12131011);
      chk($sformatf("t4_stall%0d_valid", c), bus.dout_valid, 1'b1);
      @(posedge clk); #1;
    end
    chk("t4_words_stalled", bus.words_done, 32'd1);
    bus.dout_ready = 1'b1;
    #1;
    chk("t4_release_ready", bus.din_ready, 1'b1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    chk("t4_second", bus.dout_data, 32'h25242726);
    chk("t4_words", bus.words_done, 32'd2);
    @(posedge clk); #1;
    chk("t4_idle", bus.dout_valid, 1'b0);

    // Test 5: empty buffer stalls data; latency after a push.
    apply_reset();
    bus.din_valid = 1'b1; bus.din_data = 32'h0; bus.din_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("t5_empty%0d_ready", c), bus.din_ready, 1'b0);
      chk($sformatf("t5_empty%0d_valid", c), bus.dout_valid, 1'b0);
      @(posedge clk); #1;
    end
    bus.ks_valid = 1'b1; bus.ks_data = K0;
    @(posedge clk); #1;
    bus.ks_valid = 1'b0;
    chk("t5_push_cycle_valid", bus.dout_valid, 1'b0);
    chk("t5_push_cycle_ready", bus.din_ready, 1'b1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    chk("t5_out_valid", bus.dout_valid, 1'b1);
    chk("t5_out_data", bus.dout_data, 32'h03020100);

    // Test 6: reset mid-block drops state and realigns to chunk 0.
    apply_reset();
    push_block(K0);
    push_block(K1);
    send_word(32'hFFFFFFFF, 1'b0);
    chk("t6_pre_data", bus.dout_data, 32'hFCFDFEFF);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", bus.dout_valid, 1'b0);
    chk("t6_rst_words", bus.words_done, 32'd0);
    chk("t6_rst_ks_ready", bus.ks_ready, 1'b0);
    chk("t6_rst_din_ready", bus.din_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t6_empty", bus.din_ready, 1'b0);
    push_block(K2);
    send_word(32'h0, 1'b0);
    chk("t6_chunk0", bus.dout_data, 32'h23222120);
    chk("t6_words", bus.words_done, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/snowv_keystream_xor.md
Name: snowv_keystream_xor

Overview:
- Consumer end of the SNOW-V keystream interface. Takes 128-bit keystream blocks from the generator (LFSR + FSM pipeline) and XORs them, DW bits at a time, onto a plaintext or ciphertext word stream.
- The same block serves both encryption and decryption, because XOR is symmetric.
- A 2-entry keystream buffer decouples generator cadence from data cadence.
- Sits between the keystream generator and the system data path.

Parameters:
- DW, 32, data word width in bits; legal values 8, 16, 32, 64, 128 (must divide 128).
- KS_DEPTH, 2, keystream buffer depth in 128-bit blocks; fixed at 2 in this revision.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ks_valid  in  1  keystream block valid.
- ks_ready  out  1  buffer can accept a block.
- ks_data  in  128  keystream block; chunk i is ks_data[DW*i +: DW].
- din_valid  in  1  input data word valid.
- din_ready  out  1  block can accept a data word.
- din_data  in  DW  plaintext or ciphertext word.
- din_last  in  1  final word of the message.
- dout_valid  out  1  output word valid.
- dout_ready  in  1  downstream accepts the output word.
- dout_data  out  DW  din_data XOR keystream chunk.
- dout_last  out  1  registered copy of din_last.
- words_done  out  32  count of data words transferred since reset; wraps modulo 2^32.

Behaviour:
- Reset (asynchronous, active-high):
  - Buffer empty; chunk index = 0.
  - dout_valid = 0, dout_data = 0, dout_last = 0.
  - words_done = 0; ks_ready = 0 while rst is high.
- Definitions:
  - N = 128/DW chunks per block.
  - Keystream push when ks_valid && ks_ready.
  - Data transfer when din_valid && din_ready.
- ks_ready = (count < 2) || pop_this_cycle. When the buffer is full, a simultaneous push and pop is legal.
- din_ready = (count > 0) && (!dout_valid || dout_ready). This is a combinational function of registered state and dout_ready. No combinational path from din_valid.
- On a data transfer:
  - dout_data <= din_data ^ head_block[DW*idx +: DW].
  - dout_last <= din_last; dout_valid <= 1; words_done += 1.
  - Latency is exactly 1 cycle from the din handshake to dout_valid.
- Chunk index and pop on a transfer:
  - If idx == N-1 or din_last: pop the head block, idx <= 0.
  - Otherwise idx <= idx+1.
  - Any unused chunks of a block are discarded at message end, so every message starts on a fresh block.
- Output register: if dout_valid && dout_ready and there is no transfer that cycle, dout_valid <= 0. Data is held stable while dout_valid && !dout_ready.
- Buffer is a 2-entry FIFO with read/write pointers and a count in 0..2. Simultaneous push and pop leaves the count unchanged.
- Empty buffer: din_ready = 0. Data stalls; no word is ever XORed with a stale or zero block.
- Full buffer with no pop: ks_ready = 0 and the generator stalls.
- DW = 128: N = 1, so every transfer pops.
- A reset asserted mid-message drops all buffered keystream and any pending output word. The first block pushed after reset is aligned to chunk 0.

Decomposition:
- Shared package snowv_pkg holds:
  - KS_W = 128.
  - The legal-DW check.
  - A ks_block_t typedef (128-bit).
- One sub-module, snowv_ks_fifo: a 2-entry, 128-bit valid/ready FIFO with a count output, instantiated once.
- XOR datapath, chunk index, output register and counter stay in the top module.

Test Plan:
1. DW=32: push blocks K0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100 and K1; send 4 words of 32'hFFFFFFFF with last on word 4 -> dout = FCFDFEFF, F8F9FAFB, F4F5F6F7, F0F1F2F3 (K0 chunks 0..3 inverted, chunk 0 first); K1 not consumed; words_done = 4.
2. Message of 2 words, last on word 2, then a new word -> the new word uses K1 chunk 0; K0 chunks 2-3 discarded.
3. Push 3 blocks with no data -> ks_ready drops after 2 accepted. Then one data word with last, while ks_valid held -> third block accepted in the same cycle as the pop; count stays 2.
4. dout_ready held low for 5 cycles with din_valid high -> din_ready = 0, dout_data stable, no words lost or duplicated.
5. din_valid high with the buffer empty for 10 cycles -> din_ready = 0, dout_valid = 0. Push one block -> first output appears 2 cycles after the push (one cycle for din_ready, one cycle of latency).
6. Assert rst mid-block (after 1 of 4 chunks used) -> dout_valid = 0, words_done = 0, buffer empty. The next block starts at chunk 0.
